// File: rtl/cpu_pkg.sv
// Shared execute-path definitions: shifter encodings, operand-2 shift field
// positions and the decoded shift operand record.
package cpu_pkg;

  localparam int CPU_DATA_W = 32;

  localparam logic [1:0] SH_LSL = 2'b00;
  localparam logic [1:0] SH_LSR = 2'b01;

  localparam int SHIFT_IMM_HI  = 11;
  localparam int SHIFT_IMM_LO  = 7;
  localparam int SHIFT_TYPE_HI = 6;
  localparam int SHIFT_TYPE_LO = 5;
  localparam int SHIFT_REG_BIT = 4;

  typedef struct packed {
    logic [CPU_DATA_W-1:0] data;
    logic [4:0]            amount;
    logic [1:0]            sh_type;
    logic                  unsupported;
  } shift_op_t;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_state_t;

  // ASR and ROR have no shifter support; they degrade to LSR.
  function automatic logic [1:0] map_shift_type(input logic [1:0] field);
    return (field == 2'b00) ? SH_LSL : SH_LSR;
  endfunction

endpackage

// File: rtl/shift_field_decode.sv
// Combinational decode of the operand-2 shift field plus Rm/Rs into a
// ready-to-use shifter operand record.
module shift_field_decode
  import cpu_pkg::*;
(
  input  logic [31:0]           instr,
  input  logic [CPU_DATA_W-1:0] rm_val,
  input  logic [CPU_DATA_W-1:0] rs_val,
  output shift_op_t             op
);

  logic [1:0] w_type_field;
  logic       w_rs_saturate;
  logic       w_unused;

  assign w_type_field  = instr[SHIFT_TYPE_HI:SHIFT_TYPE_LO];
  assign w_rs_saturate = |rs_val[7:5];
  assign w_unused      = ^{instr[31:12], instr[3:0], rs_val[CPU_DATA_W-1:8]};

  always_comb begin
    op             = '0;
    op.unsupported = w_type_field[1];
    op.sh_type     = map_shift_type(w_type_field);
    op.data        = rm_val;
    if (!instr[SHIFT_REG_BIT]) begin
      op.amount = instr[SHIFT_IMM_HI:SHIFT_IMM_LO];
    end else if (w_rs_saturate) begin
      // Any shift of 32 or more yields zero for both LSL and LSR.
      op.data    = '0;
      op.amount  = 5'd0;
      op.sh_type = SH_LSL;
    end else begin
      op.amount = rs_val[4:0];
    end
  end

endmodule

// File: rtl/shift_operand_stage.sv
// Registered shifter-operand stage: decode on push into a 2-entry skid
// buffer whose head drives the barrel shifter inputs.
module shift_operand_stage
  import cpu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       instr,
  input  logic [DATA_W-1:0] rm_val,
  input  logic [DATA_W-1:0] rs_val,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] sh_input,
  output logic [4:0]        sh_amount,
  output logic [1:0]        sh_type,
  output logic              out_unsupported,
  output logic [1:0]        dbg_state
);

  // Handshake: a beat transfers on a rising edge where valid and ready are
  // both high; valid never waits on ready, and in_ready is a pure register.
  occ_state_t r_state, w_state_nxt;
  shift_op_t  r_q0, r_q1, w_q0_nxt, w_q1_nxt;
  shift_op_t  w_dec;
  logic       r_in_ready, w_in_ready_nxt;
  logic       w_push, w_pop;

  shift_field_decode u_decode (
    .instr  (instr),
    .rm_val (rm_val),
    .rs_val (rs_val),
    .op     (w_dec)
  );

  always_comb begin
    w_push      = in_valid & r_in_ready & ~flush;
    w_pop       = (r_state != OCC_EMPTY) & out_ready;
    w_state_nxt = r_state;
    w_q0_nxt    = r_q0;
    w_q1_nxt    = r_q1;
    if (flush) begin
      w_state_nxt = OCC_EMPTY;
    end else begin
      case (r_state)
        OCC_EMPTY: begin
          if (w_push) begin
            w_q0_nxt    = w_dec;
            w_state_nxt = OCC_ONE;
          end
        end
        OCC_ONE: begin
          if (w_push && w_pop) begin
            w_q0_nxt = w_dec;
          end else if (w_push) begin
            w_q1_nxt    = w_dec;
            w_state_nxt = OCC_FULL;
          end else if (w_pop) begin
            w_state_nxt = OCC_EMPTY;
          end
        end
        OCC_FULL: begin
          // in_ready is low here, so only a pop can occur.
          if (w_pop) begin
            w_q0_nxt    = r_q1;
            w_state_nxt = OCC_ONE;
          end
        end
        default: w_state_nxt = OCC_EMPTY;
      endcase
    end
    w_in_ready_nxt = (32'(w_state_nxt) < DEPTH);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= OCC_EMPTY;
      r_in_ready <= 1'b1;
      r_q0       <= '0;
      r_q1       <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_in_ready <= w_in_ready_nxt;
      r_q0       <= w_q0_nxt;
      r_q1       <= w_q1_nxt;
    end
  end

  assign in_ready        = r_in_ready;
  assign out_valid       = (r_state != OCC_EMPTY);
  assign sh_input        = r_q0.data;
  assign sh_amount       = r_q0.amount;
  assign sh_type         = r_q0.sh_type;
  assign out_unsupported = r_q0.unsupported;
  assign dbg_state       = r_state;

  a_hold_stable: assert property (@(posedge clk) disable iff (rst)
    (out_valid && !out_ready) |=> $stable({sh_input, sh_amount, sh_type, out_unsupported}));

endmodule

// File: tb/tb_shift_operand_stage.sv
// Directed bench for shift_operand_stage with an expected-value queue
// drained by an independent output monitor.
module tb_shift_operand_stage;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready, out_unsupported;
  logic [31:0] instr, rm_val, rs_val, sh_input;
  logic [4:0]  sh_amount;
  logic [1:0]  sh_type, dbg_state;

  int checks = 0;
  int errors = 0;
  logic [39:0] exp_q[$];

  always #5 clk = ~clk;

  shift_operand_stage #(.DATA_W(32), .DEPTH(2)) dut (
    .clk             (clk),
    .rst             (rst),
    .flush           (flush),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .instr           (instr),
    .rm_val          (rm_val),
    .rs_val          (rs_val),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .sh_input        (sh_input),
    .sh_amount       (sh_amount),
    .sh_type         (sh_type),
    .out_unsupported (out_unsupported),
    .dbg_state       (dbg_state)
  );

  function automatic logic [39:0] pk(input logic [31:0] d, input logic [4:0] a,
                                     input logic [1:0] t, input logic u);
    return {d, a, t, u};
  endfunction

  function automatic logic [31:0] mk_instr(input logic [4:0] amt, input logic [1:0] typ,
                                           input logic reg_bit);
    return {20'h0, amt, typ, reg_bit, 4'h0};
  endfunction

  function automatic logic [39:0] cur_out();
    return {sh_input, sh_amount, sh_type, out_unsupported};
  endfunction

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Monitor: every presented beat is compared with the oldest expectation.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL mon_unexpected actual=%h expected=none", cur_out());
      end else begin
        check("mon_out", cur_out(), exp_q.pop_front());
      end
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic push(input logic [31:0] ins, input logic [31:0] rm, input logic [31:0] rs,
                      input logic [39:0] exp);
    int n = 0;
    instr = ins; rm_val = rm; rs_val = rs; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL push_timeout in_ready=0 expected=1");
    end else begin
      exp_q.push_back(exp);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    out_ready = 1'b1;
    while (exp_q.size() != 0 && n < 50) begin
      n++;
      @(posedge clk); #1;
    end
    check("drain_done", 40'(exp_q.size()), 40'd0);
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    instr = '0; rm_val = '0; rs_val = '0;
    cycles(3);
    rst = 1'b0;
    check("rst_out_valid", 40'(out_valid), 40'd0);
    check("rst_in_ready", 40'(in_ready), 40'd1);
    check("rst_outputs", cur_out(), 40'd0);

    // Immediate LSL #3, 1-cycle latency, then back-to-back register shifts.
    out_ready = 1'b1;
    push(mk_instr(5'd3, 2'b00, 1'b0), 32'h0000_0001, 32'h0, pk(32'h1, 5'd3, 2'b00, 1'b0));
    check("t1_out_valid", 40'(out_valid), 40'd1);
    push(mk_instr(5'd0, 2'b01, 1'b1), 32'hFFFF_FFFF, 32'h0000_0120, pk(32'h0, 5'd0, 2'b00, 1'b0));
    push(mk_instr(5'd0, 2'b01, 1'b1), 32'hFFFF_FFFF, 32'h0000_0108, pk(32'hFFFF_FFFF, 5'd8, 2'b01, 1'b0));
    push(mk_instr(5'd0, 2'b01, 1'b1), 32'h1234_5678, 32'h0000_001F, pk(32'h1234_5678, 5'd31, 2'b01, 1'b0));
    push(mk_instr(5'd0, 2'b00, 1'b1), 32'hCAFE_0001, 32'hFFFF_FF05, pk(32'hCAFE_0001, 5'd5, 2'b00, 1'b0));
    push(mk_instr(5'd0, 2'b10, 1'b1), 32'hDEAD_BEEF, 32'h0000_0040, pk(32'h0, 5'd0, 2'b00, 1'b1));
    drain();

    // Backpressure fill and single-cycle release.
    out_ready = 1'b0;
    push(mk_instr(5'd2, 2'b00, 1'b0), 32'hAAAA_0001, 32'h0, pk(32'hAAAA_0001, 5'd2, 2'b00, 1'b0));
    push(mk_instr(5'd7, 2'b01, 1'b0), 32'hBBBB_0002, 32'h0, pk(32'hBBBB_0002, 5'd7, 2'b01, 1'b0));
    check("fill_in_ready", 40'(in_ready), 40'd0);
    check("fill_head_a", cur_out(), pk(32'hAAAA_0001, 5'd2, 2'b00, 1'b0));
    cycles(2);
    check("hold_head_a", cur_out(), pk(32'hAAAA_0001, 5'd2, 2'b00, 1'b0));
    check("hold_in_ready", 40'(in_ready), 40'd0);
    out_ready = 1'b1;
    cycles(1);
    out_ready = 1'b0;
    check("pop_in_ready", 40'(in_ready), 40'd1);
    check("pop_head_b", cur_out(), pk(32'hBBBB_0002, 5'd7, 2'b01, 1'b0));
    drain();

    // ROR request degrades to LSR and is flagged.
    push(mk_instr(5'd4, 2'b11, 1'b0), 32'h8000_00F0, 32'h0, pk(32'h8000_00F0, 5'd4, 2'b01, 1'b1));
    drain();

    // Flush with two held entries and a concurrent push.
    out_ready = 1'b0;
    push(mk_instr(5'd1, 2'b00, 1'b0), 32'h0000_0C01, 32'h0, pk(32'h0000_0C01, 5'd1, 2'b00, 1'b0));
    push(mk_instr(5'd9, 2'b00, 1'b0), 32'h0000_0D02, 32'h0, pk(32'h0000_0D02, 5'd9, 2'b00, 1'b0));
    flush = 1'b1; in_valid = 1'b1; instr = mk_instr(5'd6, 2'b00, 1'b0); rm_val = 32'h0000_0E03;
    cycles(1);
    flush = 1'b0; in_valid = 1'b0;
    exp_q.delete();
    check("flush2_out_valid", 40'(out_valid), 40'd0);
    check("flush2_in_ready", 40'(in_ready), 40'd1);

    // Flush with one held entry while in_ready is high: the push is dropped.
    push(mk_instr(5'd5, 2'b01, 1'b0), 32'h0000_0F04, 32'h0, pk(32'h0000_0F04, 5'd5, 2'b01, 1'b0));
    flush = 1'b1; in_valid = 1'b1; instr = mk_instr(5'd8, 2'b00, 1'b0); rm_val = 32'h0000_0A05;
    cycles(1);
    flush = 1'b0; in_valid = 1'b0;
    exp_q.delete();
    check("flush1_out_valid", 40'(out_valid), 40'd0);
    out_ready = 1'b1;
    cycles(3);
    check("flush_no_ghost", 40'(out_valid), 40'd0);

    // Reset with one entry held under backpressure.
    out_ready = 1'b0;
    push(mk_instr(5'd12, 2'b01, 1'b0), 32'h5555_AAAA, 32'h0, pk(32'h5555_AAAA, 5'd12, 2'b01, 1'b0));
    rst = 1'b1;
    cycles(1);
    rst = 1'b0;
    exp_q.delete();
    check("rst2_out_valid", 40'(out_valid), 40'd0);
    check("rst2_in_ready", 40'(in_ready), 40'd1);
    check("rst2_outputs", cur_out(), 40'd0);
    check("rst2_state", 40'(dbg_state), 40'd0);
    out_ready = 1'b1;
    push(mk_instr(5'd16, 2'b00, 1'b0), 32'h0000_00FF, 32'h0, pk(32'h0000_00FF, 5'd16, 2'b00, 1'b0));
    check("restart_out_valid", 40'(out_valid), 40'd1);
    drain();
    cycles(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
